// File: rtl/fp_to_int_convert_pkg.sv
// Shared FPU definitions for the float-to-integer path.
// Contents: rounding-mode enum, stage-1 operand classes, and format helpers
// (fraction width, exponent width, bias, saturated integer pattern) as functions of W.
package fp_to_int_convert_pkg;

  typedef enum logic [1:0] {
    RM_RN = 2'd0,  // nearest, ties to even
    RM_RZ = 2'd1,  // toward zero
    RM_RP = 2'd2,  // toward +inf
    RM_RM = 2'd3   // toward -inf
  } rmode_e;

  // Operand class decided in stage 1.
  typedef enum logic [1:0] {
    KindSmall = 2'd0,  // |x| < 1, including zero and subnormals
    KindNorm  = 2'd1,  // 1 <= |x| < 2^W, needs shifting and range check
    KindInv   = 2'd2   // NaN, infinity or certainly out of range
  } kind_e;

  function automatic int unsigned fp_fw(int unsigned w);
    return (w == 64) ? 52 : 23;
  endfunction

  function automatic int unsigned fp_ew(int unsigned w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int unsigned fp_bias(int unsigned w);
    return (1 << (fp_ew(w) - 1)) - 1;
  endfunction

  // Saturated result for invalid conversions: 2^(W-1)-1.
  function automatic logic [63:0] fp_int_invalid(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fp_to_int_convert_if.sv
// Request/response bundle of the float-to-integer converter.
// Signals: en (launch), in (IEEE-754 operand), rmode, tag; out, out_valid, out_tag,
// invalid, and inexact when FP_TO_INT_FLAGS_EN is defined.
// Modports: master drives requests (FPU issue side), slave is the converter.
interface fp_to_int_convert_if
  import fp_to_int_convert_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned TW = 6
);
  logic          en;
  logic [W-1:0]  in;
  rmode_e        rmode;
  logic [TW-1:0] tag;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [TW-1:0] out_tag;
  logic          invalid;
`ifdef FP_TO_INT_FLAGS_EN
  logic          inexact;
`endif

  modport master (
`ifdef FP_TO_INT_FLAGS_EN
    input  inexact,
`endif
    output en, in, rmode, tag,
    input  out, out_valid, out_tag, invalid
  );

  modport slave (
`ifdef FP_TO_INT_FLAGS_EN
    output inexact,
`endif
    input  en, in, rmode, tag,
    output out, out_valid, out_tag, invalid
  );
endinterface

// File: rtl/fp_round_inc.sv
// Rounding-increment decision for IEEE-754 directed and nearest-even modes.
// Ports: i_sign (operand sign), i_lsb (kept lsb), i_g (guard), i_s (sticky),
// i_rmode (rounding mode) -> o_inc (add one to the magnitude). Purely combinational.
module fp_round_inc
  import fp_to_int_convert_pkg::*;
(
  input  logic   i_sign,
  input  logic   i_lsb,
  input  logic   i_g,
  input  logic   i_s,
  input  rmode_e i_rmode,
  output logic   o_inc
);
  always_comb begin
    o_inc = 1'b0;
    case (i_rmode)
      RM_RN:   o_inc = i_g & (i_s | i_lsb);
      RM_RZ:   o_inc = 1'b0;
      RM_RP:   o_inc = ~i_sign & (i_g | i_s);
      RM_RM:   o_inc = i_sign & (i_g | i_s);
      default: o_inc = 1'b0;
    endcase
  end
endmodule

// File: rtl/fp_to_int_convert.sv
// Two-stage float-to-signed-integer converter (cvt/trunc/round/ceil/floor).
// W=32: binary32 -> word, W=64: binary64 -> long. Latency 2, throughput 1/cycle.
// Ports: clk, reset (synchronous, active high), bus (slave modport of
// fp_to_int_convert_if carrying en/in/rmode/tag and out/out_valid/out_tag/invalid).
// Macro FP_TO_INT_FLAGS_EN adds the inexact flag output.
module fp_to_int_convert
  import fp_to_int_convert_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned TW = 6
) (
  input logic                clk,
  input logic                reset,
  fp_to_int_convert_if.slave bus
);
  localparam int unsigned FW  = fp_fw(W);
  localparam int unsigned EW  = fp_ew(W);
  localparam int unsigned SW  = $clog2(W);
  localparam int unsigned FRW = W + FW;  // W integer bits over FW fraction bits
  localparam logic [EW-1:0] EXP_BIAS = EW'(fp_bias(W));
  localparam logic [EW-1:0] EXP_TOP  = EW'(fp_bias(W) + W - 1);  // e = W-1
  localparam logic [W:0]    MAG_LIM  = {2'b01, {(W - 1){1'b0}}};  // 2^(W-1)
  localparam logic [W-1:0]  INT_INVALID = W'(fp_int_invalid(W));

  // ---------------- Stage 1: unpack and classify ----------------
  logic          w_sign;
  logic [EW-1:0] w_exp;
  logic [FW-1:0] w_frac;
  kind_e         w_kind;
  logic [SW-1:0] w_shamt;
  logic          w_g_small;
  logic          w_s_small;

  always_comb begin
    w_sign    = bus.in[W-1];
    w_exp     = bus.in[W-2 -: EW];
    w_frac    = bus.in[FW-1:0];
    w_kind    = KindSmall;
    w_shamt   = '0;
    w_g_small = 1'b0;
    w_s_small = 1'b0;
    if (w_exp > EXP_TOP) begin
      // Also catches the all-ones exponent (inf/NaN).
      w_kind = KindInv;
    end else if (w_exp >= EXP_BIAS) begin
      w_kind  = KindNorm;
      w_shamt = SW'(w_exp - EXP_BIAS);
    end else if (w_exp == EXP_BIAS - EW'(1)) begin
      // 0.5 <= |x| < 1: hidden bit is the guard, fraction is sticky.
      w_g_small = 1'b1;
      w_s_small = |w_frac;
    end else if ((w_exp != '0) || (w_frac != '0)) begin
      // Below one half, including subnormals.
      w_s_small = 1'b1;
    end
  end

  logic          r1_valid;
  logic          r1_sign;
  kind_e         r1_kind;
  logic [SW-1:0] r1_shamt;
  logic [FW:0]   r1_mant;
  logic          r1_g_small;
  logic          r1_s_small;
  rmode_e        r1_rmode;
  logic [TW-1:0] r1_tag;

  // ---------------- Stage 2: shift, round, saturate ----------------
  // The mantissa sits with its hidden bit at weight 2^0; shifting left by e puts
  // the integer part in the top W bits and leaves FW fraction bits below.
  logic [FRW-1:0] w_frame;
  logic [W-1:0]   w_mag;
  logic           w_g;
  logic           w_s;
  logic           w_inc;
  logic [W:0]     w_sum;
  logic           w_ovf;
  logic [W-1:0]   w_res;

  always_comb begin
    w_frame = FRW'(r1_mant) << r1_shamt;
    if (r1_kind == KindNorm) begin
      w_mag = w_frame[FRW-1:FW];
      w_g   = w_frame[FW-1];
      w_s   = |w_frame[FW-2:0];
    end else begin
      w_mag = '0;
      w_g   = r1_g_small;
      w_s   = r1_s_small;
    end
  end

  fp_round_inc u_round_inc (
    .i_sign  (r1_sign),
    .i_lsb   (w_mag[0]),
    .i_g     (w_g),
    .i_s     (w_s),
    .i_rmode (r1_rmode),
    .o_inc   (w_inc)
  );

  always_comb begin
    w_sum = {1'b0, w_mag} + {{W{1'b0}}, w_inc};
    // Negative magnitudes may reach exactly 2^(W-1); positive ones may not.
    w_ovf = (r1_kind == KindInv) ||
            (r1_sign ? (w_sum > MAG_LIM) : (w_sum >= MAG_LIM));
    if (w_ovf) begin
      w_res = INT_INVALID;
    end else if (r1_sign) begin
      w_res = -w_sum[W-1:0];
    end else begin
      w_res = w_sum[W-1:0];
    end
  end

  logic          r_out_valid;
  logic [W-1:0]  r_out;
  logic [TW-1:0] r_out_tag;
  logic          r_invalid;
`ifdef FP_TO_INT_FLAGS_EN
  logic          r_inexact;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_tag   <= '0;
      r_invalid   <= 1'b0;
`ifdef FP_TO_INT_FLAGS_EN
      r_inexact   <= 1'b0;
`endif
    end else begin
      r1_valid    <= bus.en;
      r_out_valid <= r1_valid;
      if (bus.en) begin
        r1_sign    <= w_sign;
        r1_kind    <= w_kind;
        r1_shamt   <= w_shamt;
        r1_mant    <= {(w_exp != '0), w_frac};
        r1_g_small <= w_g_small;
        r1_s_small <= w_s_small;
        r1_rmode   <= bus.rmode;
        r1_tag     <= bus.tag;
      end
      if (r1_valid) begin
        r_out     <= w_res;
        r_out_tag <= r1_tag;
        r_invalid <= w_ovf;
`ifdef FP_TO_INT_FLAGS_EN
        r_inexact <= ~w_ovf & (w_g | w_s);
`endif
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.out_tag   = r_out_tag;
  assign bus.invalid   = r_invalid;
`ifdef FP_TO_INT_FLAGS_EN
  assign bus.inexact   = r_inexact;
`endif

endmodule

// File: tb/tb_fp_to_int_convert.sv
// Bench for fp_to_int_convert: one W=32 and one W=64 instance, directed vectors with
// hand-computed literals plus an exact-arithmetic reference model checked every
// cycle out_valid is high.
module tb_fp_to_int_convert;
  import fp_to_int_convert_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_to_int_convert_if #(.W(32), .TW(6)) bus32 ();
  fp_to_int_convert_if #(.W(64), .TW(6)) bus64 ();

  fp_to_int_convert #(.W(32), .TW(6)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  fp_to_int_convert #(.W(64), .TW(6)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64));

  typedef struct {
    logic [63:0] res;
    logic        inv;
    logic        inx;
    logic [5:0]  tag;
    int          cyc;
    bit          has_lit;
    logic [63:0] lres;
    logic        linv;
    logic        linx;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   nerr = 0;
  int   nchk = 0;
  int   cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // Exact value = mant * 2^(e-fw); round the exact remainder, then range-check.
  function automatic void model(input logic [63:0] bits, input int w, input logic [1:0] rm,
                                output logic [63:0] res, output logic inv,
                                output logic inx);
    int fw, ew, bias, ex, e, t, n;
    logic sign, up;
    logic [127:0] mant, q, rem, half, lim;
    fw   = (w == 64) ? 52 : 23;
    ew   = (w == 64) ? 11 : 8;
    bias = (1 << (ew - 1)) - 1;
    sign = bits[w-1];
    ex   = int'((bits >> fw) & ((64'd1 << ew) - 64'd1));
    mant = 128'(bits & ((64'd1 << fw) - 64'd1));
    lim  = 128'd1 << (w - 1);
    inv  = 1'b0;
    inx  = 1'b0;
    res  = '0;
    q    = '0;
    rem  = '0;
    half = '1;
    if (ex == (1 << ew) - 1) begin
      inv = 1'b1;
    end else begin
      if (ex == 0) e = 1 - bias;
      else begin
        e = ex - bias;
        mant = mant | (128'd1 << fw);
      end
      if (e > w) inv = 1'b1;
      else begin
        t = e - fw;
        if (t >= 0) q = mant << t;
        else begin
          n = -t;
          if (n >= 120) rem = mant;
          else begin
            q    = mant >> n;
            rem  = mant - (q << n);
            half = 128'd1 << (n - 1);
          end
        end
        case (rm)
          2'd0:    up = (rem > half) || (rem == half && q[0]);
          2'd1:    up = 1'b0;
          2'd2:    up = !sign && rem != 0;
          default: up = sign && rem != 0;
        endcase
        q = q + 128'(up);
        if (sign ? (q > lim) : (q >= lim)) inv = 1'b1;
        else begin
          res = sign ? 64'(-q) : 64'(q);
          if (w == 32) res = res & 64'hFFFF_FFFF;
          inx = (rem != 0);
        end
      end
    end
    if (inv) res = 64'(lim - 1);
  endfunction

  task automatic issue(input bit is64, input logic [63:0] bits, input logic [1:0] rm,
                       input logic [5:0] tg, input bit has_lit, input logic [63:0] lres,
                       input logic linv, input logic linx);
    exp_t e;
    @(posedge clk);
    #1;
    model(bits, is64 ? 64 : 32, rm, e.res, e.inv, e.inx);
    e.tag = tg; e.cyc = cyc; e.has_lit = has_lit;
    e.lres = lres; e.linv = linv; e.linx = linx;
    bus32.en = !is64;
    bus64.en = is64;
    if (is64) begin
      bus64.in = bits; bus64.rmode = rmode_e'(rm); bus64.tag = tg;
      q64.push_back(e);
    end else begin
      bus32.in = bits[31:0]; bus32.rmode = rmode_e'(rm); bus32.tag = tg;
      q32.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus32.en = 1'b0;
      bus64.en = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (bus32.out_valid) begin
      if (q32.size() == 0) chk("w32 out_valid with nothing pending", 64'(bus32.out_valid), 0);
      else begin
        e32 = q32.pop_front();
        chk("w32 out vs model", 64'(bus32.out), e32.res);
        chk("w32 invalid vs model", 64'(bus32.invalid), 64'(e32.inv));
        chk("w32 out_tag", 64'(bus32.out_tag), 64'(e32.tag));
        chk("w32 latency", 64'(cyc), 64'(e32.cyc + 2));
`ifdef FP_TO_INT_FLAGS_EN
        chk("w32 inexact vs model", 64'(bus32.inexact), 64'(e32.inx));
        if (e32.has_lit) chk("w32 inexact literal", 64'(bus32.inexact), 64'(e32.linx));
`endif
        if (e32.has_lit) begin
          chk("w32 out literal", 64'(bus32.out), e32.lres);
          chk("w32 invalid literal", 64'(bus32.invalid), 64'(e32.linv));
        end
      end
    end
    if (bus64.out_valid) begin
      if (q64.size() == 0) chk("w64 out_valid with nothing pending", 64'(bus64.out_valid), 0);
      else begin
        e64 = q64.pop_front();
        chk("w64 out vs model", bus64.out, e64.res);
        chk("w64 invalid vs model", 64'(bus64.invalid), 64'(e64.inv));
        chk("w64 out_tag", 64'(bus64.out_tag), 64'(e64.tag));
        chk("w64 latency", 64'(cyc), 64'(e64.cyc + 2));
`ifdef FP_TO_INT_FLAGS_EN
        chk("w64 inexact vs model", 64'(bus64.inexact), 64'(e64.inx));
        if (e64.has_lit) chk("w64 inexact literal", 64'(bus64.inexact), 64'(e64.linx));
`endif
        if (e64.has_lit) begin
          chk("w64 out literal", bus64.out, e64.lres);
          chk("w64 invalid literal", 64'(bus64.invalid), 64'(e64.linv));
        end
      end
    end
  end

  // Directed W=32 table: operand, rmode, expected out, invalid, inexact.
  typedef struct {
    logic [31:0] op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        inv;
    logic        inx;
  } vec32_t;

  vec32_t v32[] = '{
    '{32'h3FC00000, 2'd0, 32'h00000002, 1'b0, 1'b1},  // 1.5 RN
    '{32'h3FC00000, 2'd1, 32'h00000001, 1'b0, 1'b1},  // 1.5 RZ
    '{32'h3FC00000, 2'd2, 32'h00000002, 1'b0, 1'b1},  // 1.5 RP
    '{32'h3FC00000, 2'd3, 32'h00000001, 1'b0, 1'b1},  // 1.5 RM
    '{32'hBFC00000, 2'd0, 32'hFFFFFFFE, 1'b0, 1'b1},  // -1.5 RN
    '{32'hBFC00000, 2'd1, 32'hFFFFFFFF, 1'b0, 1'b1},  // -1.5 RZ
    '{32'hBFC00000, 2'd3, 32'hFFFFFFFE, 1'b0, 1'b1},  // -1.5 RM
    '{32'h40200000, 2'd0, 32'h00000002, 1'b0, 1'b1},  // 2.5 RN ties to even
    '{32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0},  // -2^31 exact
    '{32'h4F000000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0},  // 2^31 overflow
    '{32'hCF000001, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b0},  // just below -2^31
    '{32'h7FC00000, 2'd0, 32'h7FFFFFFF, 1'b1, 1'b0},  // NaN
    '{32'hFF800000, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b0},  // -inf
    '{32'h00000001, 2'd2, 32'h00000001, 1'b0, 1'b1},  // +denormal RP
    '{32'h00000001, 2'd1, 32'h00000000, 1'b0, 1'b1},  // +denormal RZ
    '{32'h00000001, 2'd0, 32'h00000000, 1'b0, 1'b1},  // +denormal RN
    '{32'h80000001, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b1},  // -denormal RM
    '{32'h80000000, 2'd0, 32'h00000000, 1'b0, 1'b0},  // -0
    '{32'h3F000000, 2'd0, 32'h00000000, 1'b0, 1'b1},  // 0.5 RN ties to even
    '{32'h3F000000, 2'd2, 32'h00000001, 1'b0, 1'b1},  // 0.5 RP
    '{32'hBF000000, 2'd2, 32'h00000000, 1'b0, 1'b1},  // -0.5 RP gives +0
    '{32'h3F7FFFFF, 2'd0, 32'h00000001, 1'b0, 1'b1},  // just below 1 RN
    '{32'hBF800000, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b0},  // -1 exact
    '{32'h4EFFFFFF, 2'd1, 32'h7FFFFF80, 1'b0, 1'b0}   // largest float below 2^31
  };

  initial begin
    bus32.en = 1'b0; bus32.in = '0; bus32.rmode = RM_RN; bus32.tag = '0;
    bus64.en = 1'b0; bus64.in = '0; bus64.rmode = RM_RN; bus64.tag = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset w32 out_valid", 64'(bus32.out_valid), 0);
    chk("reset w32 out", 64'(bus32.out), 0);
    chk("reset w32 out_tag", 64'(bus32.out_tag), 0);
    chk("reset w32 invalid", 64'(bus32.invalid), 0);
    chk("reset w64 out_valid", 64'(bus64.out_valid), 0);
    chk("reset w64 out", bus64.out, 0);
    reset = 1'b0;
    idle(2);

    foreach (v32[i])
      issue(1'b0, 64'(v32[i].op), v32[i].rm, 6'(i), 1'b1, 64'(v32[i].res), v32[i].inv,
            v32[i].inx);
    idle(3);

    issue(1'b1, 64'h41DFFFFFFFE00000, 2'd0, 6'd1, 1'b1, 64'h0000000080000000, 1'b0, 1'b1);
    issue(1'b1, 64'h43E0000000000000, 2'd0, 6'd2, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0);
    issue(1'b1, 64'hC3E0000000000000, 2'd1, 6'd3, 1'b1, 64'h8000000000000000, 1'b0, 1'b0);
    issue(1'b1, 64'h3FF8000000000000, 2'd0, 6'd4, 1'b1, 64'h0000000000000002, 1'b0, 1'b1);
    issue(1'b1, 64'hC00C000000000000, 2'd2, 6'd5, 1'b1, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b1);
    issue(1'b1, 64'h0000000000000001, 2'd2, 6'd6, 1'b1, 64'h0000000000000001, 1'b0, 1'b1);
    idle(3);

    // Back-to-back burst, tags 1..4, all rounding modes on 3.75.
    for (int k = 1; k <= 4; k++)
      issue(1'b0, 64'h40700000, 2'(k - 1), 6'(k), 1'b0, '0, 1'b0, 1'b0);
    idle(4);

    // Reset arrives in the cycle of the 3rd issue: tag 9 completes in that same
    // cycle, tag 10 (in flight) and tag 11 (issued under reset) are dropped.
    issue(1'b0, 64'h3FC00000, 2'd0, 6'd9, 1'b0, '0, 1'b0, 1'b0);
    issue(1'b0, 64'h40200000, 2'd0, 6'd10, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus32.en = 1'b1; bus32.in = 32'h40400000; bus32.tag = 6'd11;
    @(posedge clk);
    #1;
    q32.delete();
    reset = 1'b0;
    bus32.en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no out_valid after mid-flight reset", 64'(bus32.out_valid), 0);
    end
    idle(1);

    // Traffic resumes normally after the flush.
    issue(1'b0, 64'h40400000, 2'd0, 6'd12, 1'b1, 64'h00000003, 1'b0, 1'b0);
    idle(1);

    for (int g = 0; g < 20 && (q32.size() != 0 || q64.size() != 0); g++) @(posedge clk);
    chk("w32 results drained", 64'(q32.size()), 0);
    chk("w64 results drained", 64'(q64.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
